// File: rtl/debug_register_dumper.sv
// Register-file dump engine: snapshots the register bus on request and streams it
// byte by byte (register 0 first, MSB first) through a one-byte UART start/done handshake.
module debug_register_dumper #(
  parameter int unsigned N_REGS = 32,
  parameter int unsigned REG_W  = 32,
  parameter int unsigned BYTE_W = 8
) (
  input  logic                    clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [N_REGS*REG_W-1:0] i_registers,
  input  logic                    i_tx_done,
  output logic [BYTE_W-1:0]       o_tx_data,
  output logic                    o_tx_start,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned BytesPerReg = REG_W / BYTE_W;
  localparam int unsigned NBytes      = N_REGS * BytesPerReg;
  localparam int unsigned CntW        = $clog2(NBytes);
  localparam logic [CntW-1:0] LastByte = CntW'(NBytes - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StSend = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]              r_state;
  logic [CntW-1:0]         r_cnt;
  logic [N_REGS*REG_W-1:0] r_snap;

  logic [1:0]              w_state_next;
  logic [CntW-1:0]         w_cnt_next;
  logic                    w_load;
  logic [BYTE_W-1:0]       w_bytes [NBytes];

  // Transmit order: byte n is register n/BytesPerReg, most-significant byte first.
  for (genvar n = 0; n < NBytes; n++) begin : g_bytes
    assign w_bytes[n] = r_snap[REG_W*(n/BytesPerReg)
                               + BYTE_W*(BytesPerReg-1-(n%BytesPerReg)) +: BYTE_W];
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load       = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_cnt_next   = '0;
          w_state_next = StSend;
        end
      end
      StSend: w_state_next = StWait;
      StWait: begin
        if (i_tx_done) begin
          if (r_cnt == LastByte) begin
            w_state_next = StDone;
          end else begin
            w_cnt_next   = r_cnt + CntW'(1);
            w_state_next = StSend;
          end
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_snap  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_load) begin
        r_snap <= i_registers;
      end
    end
  end

  assign o_tx_start = (r_state == StSend);
  assign o_busy     = (r_state != StIdle);
  assign o_done     = (r_state == StDone);
  assign o_tx_data  = ((r_state == StSend) || (r_state == StWait)) ? w_bytes[r_cnt] : '0;

endmodule

// File: tb/tb_debug_register_dumper.sv
// Bench for debug_register_dumper: queue scoreboard fed from a register-array model,
// with a UART TX responder, an independent output monitor and directed/random scenarios.
module tb_debug_register_dumper;

  localparam int NRegs  = 32;
  localparam int RegW   = 32;
  localparam int ByteW  = 8;
  localparam int NBytes = 128;

  logic                   clk = 1'b0;
  logic                   i_reset;
  logic                   i_start;
  logic [NRegs*RegW-1:0]  i_registers;
  logic                   i_tx_done;
  logic [ByteW-1:0]       o_tx_data;
  logic                   o_tx_start;
  logic                   o_busy;
  logic                   o_done;

  logic txd_model;
  logic glitch;
  logic stim_txd;
  assign i_tx_done = txd_model | glitch | stim_txd;

  int          n_cmp     = 0;
  int          n_fail    = 0;
  int          strobes   = 0;
  int          tx_delay  = 1;  // 0 selects a random 1..4 cycle response per byte
  bit          glitch_en = 1'b0;
  bit          await_done = 1'b0;
  logic [31:0] regs [NRegs];
  logic [8:0]  exp_q [$];     // {last_byte, data}

  debug_register_dumper dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_registers (i_registers),
    .i_tx_done   (i_tx_done),
    .o_tx_data   (o_tx_data),
    .o_tx_start  (o_tx_start),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic apply_regs();
    for (int k = 0; k < NRegs; k++) i_registers[k*RegW +: RegW] = regs[k];
  endtask

  task automatic random_regs();
    for (int k = 0; k < NRegs; k++) regs[k] = $urandom;
    apply_regs();
  endtask

  // Reference: 128 bytes, register 0..31, each most-significant byte first.
  task automatic push_dump();
    logic [31:0] w;
    for (int n = 0; n < NBytes; n++) begin
      w = regs[n/4] >> (8 * (3 - (n % 4)));
      exp_q.push_back({(n == NBytes - 1), w[7:0]});
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    push_dump();
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!o_done && cyc < 3000);
    if (!o_done) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: got no o_done, expected one within 3000 cycles at %0t",
               $time);
    end
  endtask

  // UART TX responder: pulses i_tx_done tx_delay cycles after each strobe.
  initial begin : tx_model
    int cd;
    cd        = 0;
    txd_model = 1'b0;
    forever begin
      @(negedge clk);
      txd_model = 1'b0;
      if (i_reset) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) txd_model = 1'b1;
        end
        if (o_tx_start) cd = (tx_delay == 0) ? int'($urandom_range(4, 1)) : tx_delay;
      end
    end
  end

  // Spurious i_tx_done sampled on the SEND edge, which the DUT must ignore.
  initial begin : glitcher
    glitch = 1'b0;
    forever begin
      @(negedge clk);
      glitch = glitch_en && o_tx_start && !i_reset;
    end
  end

  initial begin : monitor
    logic       rst_s;
    logic       txd_s;
    logic       after_done;
    logic [8:0] e;
    after_done = 1'b0;
    forever begin
      @(posedge clk);
      rst_s = i_reset;
      txd_s = i_tx_done;
      #1;
      if (rst_s) check("reset_outputs", {21'b0, o_tx_start, o_busy, o_done, o_tx_data}, 32'h0);
      if (after_done) begin
        check("idle_after_done", {23'b0, o_busy, o_tx_data}, 32'h0);
        after_done = 1'b0;
      end
      if (o_tx_start) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_strobe: got byte 0x%0h, expected no strobe at %0t",
                   o_tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(o_tx_data), 32'(e[7:0]));
          strobes++;
          if (e[8]) await_done = 1'b1;
        end
      end
      if (o_done) begin
        check("done_timing", {30'b0, await_done, txd_s}, 32'h3);
        await_done = 1'b0;
        after_done = 1'b1;
      end
    end
  end

  initial begin : stim
    int cyc;
    int base;
    i_reset  = 1'b1;
    i_start  = 1'b0;
    stim_txd = 1'b0;
    for (int k = 0; k < NRegs; k++) regs[k] = '0;
    apply_regs();

    // Reset held 3 cycles with start and tx_done toggling.
    repeat (3) begin
      @(negedge clk);
      i_start  = ~i_start;
      stim_txd = ~stim_txd;
    end
    i_reset  = 1'b0;
    i_start  = 1'b0;
    stim_txd = 1'b0;
    repeat (4) @(negedge clk);

    // Full dump, known pattern, responder 3 cycles behind each strobe.
    for (int k = 0; k < NRegs; k++) regs[k] = k;
    regs[1] = 32'hDEAD_BEEF;
    apply_regs();
    tx_delay = 3;
    base     = strobes;
    pulse_start();
    wait_done(cyc);
    check("full_dump_strobes", 32'(strobes - base), 32'd128);

    // Snapshot isolation: reg5 changes right after the accept edge.
    random_regs();
    regs[5] = 32'h1234_5678;
    apply_regs();
    tx_delay = 0;
    base     = strobes;
    pulse_start();
    regs[5] = 32'hFFFF_FFFF;
    apply_regs();
    wait_done(cyc);
    check("isolation_strobes", 32'(strobes - base), 32'd128);

    // Protocol robustness: starts mid-dump, tx_done pulses during SEND.
    random_regs();
    tx_delay  = 2;
    glitch_en = 1'b1;
    base      = strobes;
    pulse_start();
    repeat (40) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (150) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(cyc);
    glitch_en = 1'b0;
    check("robust_strobes", 32'(strobes - base), 32'd128);

    // Reset once byte 50 has been strobed; no done, then a clean restart.
    random_regs();
    tx_delay = 1;
    base     = strobes;
    pulse_start();
    cyc = 0;
    while ((strobes - base) < 51 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("strobes_before_reset", 32'(strobes - base), 32'd51);
    i_reset = 1'b1;
    exp_q.delete();
    await_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    repeat (5) @(negedge clk);
    random_regs();
    base = strobes;
    pulse_start();
    wait_done(cyc);
    check("min_dump_cycles", 32'(cyc + 1), 32'd257);
    check("restart_strobes", 32'(strobes - base), 32'd128);

    // Back-to-back: start held high, immediate tx_done.
    random_regs();
    tx_delay = 1;
    @(negedge clk);
    i_start = 1'b1;
    push_dump();
    base = strobes;
    wait_done(cyc);
    check("b2b_first_len", 32'(cyc), 32'd257);
    push_dump();
    @(negedge clk);
    check("b2b_idle_gap", {30'b0, o_busy, o_tx_start}, 32'h0);
    @(negedge clk);
    check("b2b_first_strobe", {31'b0, o_tx_start}, 32'h1);
    i_start = 1'b0;
    wait_done(cyc);
    check("b2b_strobes", 32'(strobes - base), 32'd256);

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_register_dumper.md
# debug_register_dumper

Debug-path reader for the decode stage's 1024-bit register-file snapshot bus (`o_register_to_debug`). On a start request it captures all 32 general-purpose registers into a local buffer. It then streams them byte by byte to the UART transmitter through a one-byte start/done handshake. The block sits between the pipeline datapath and the debug UART, and lets the host dump the register file without stalling the pipeline.

## Interface
Parameters:
- `N_REGS`, 32, number of registers in the snapshot.
- `REG_W`, 32, register width in bits.
- `BYTE_W`, 8, width of a transmitted byte.

Ports:
- Clocking and reset (already decided): one clock, `clk`. Reset `i_reset` is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_start`  in  1  dump request; sampled only in IDLE.
- `i_registers`  in  N_REGS*REG_W (1024)  register snapshot; register k occupies bits [32k+31:32k].
- `i_tx_done`  in  1  one-cycle pulse from the UART TX when the current byte has finished.
- `o_tx_data`  out  BYTE_W  byte to transmit; valid while `o_tx_start` = 1.
- `o_tx_start`  out  1  one-cycle strobe that loads `o_tx_data` into the UART TX.
- `o_busy`  out  1  high from the cycle after start is accepted until DONE is left.
- `o_done`  out  1  one-cycle pulse after the last byte completes.

## Operation
- States: IDLE, SEND, WAIT, DONE.
- Internal registers: 1024-bit `snap` buffer and a 7-bit byte counter `cnt` (0..127).
- IDLE:
  - If `i_start` = 1, load `snap` <= `i_registers`, set `cnt` <= 0, go to SEND.
  - Otherwise hold.
- SEND:
  - Assert `o_tx_start` = 1 with `o_tx_data` = byte(`cnt`), then go to WAIT unconditionally.
  - `i_tx_done` is ignored in this state.
- WAIT:
  - On `i_tx_done` = 1: if `cnt` = 127, go to DONE; otherwise `cnt` <= `cnt`+1 and go to SEND.
  - Without `i_tx_done`, hold indefinitely. There is no timeout.
- DONE: `o_done` = 1 for exactly one cycle, then go to IDLE.
- Byte ordering:
  - byte(n) = `snap`[32*(n>>2) + 8*(3-(n&3)) +: 8].
  - Registers go out in order 0 to 31, each most-significant byte first.
  - 128 bytes per dump.
- Snapshot isolation: changes on `i_registers` after the accept edge never affect the bytes sent.
- `i_start` asserted in any state other than IDLE is ignored and not queued.
- `o_busy` = 1 in SEND, WAIT and DONE; 0 in IDLE.
- `o_tx_data`:
  - Holds the current byte(`cnt`) in SEND and WAIT.
  - Reads 0 in IDLE and DONE.
  - Consumers sample it only with `o_tx_start`.

## Timing
- Reset: state IDLE, `cnt` = 0, `snap` = 0, `o_tx_start` = 0, `o_tx_data` = 0, `o_busy` = 0, `o_done` = 0. All take effect on the first edge with `i_reset` = 1.
- Reset mid-dump: returns to IDLE on the next edge from any state. No `o_done` pulse, no further `o_tx_start`. A later start begins again at byte 0.
- `i_reset` and `i_start` high together: reset wins.
- Start latency: `i_start` sampled at edge N gives `o_tx_start` = 1 during cycle N+1 (byte 0).
- Byte turnaround: `i_tx_done` sampled at edge M in WAIT gives the next `o_tx_start` during cycle M+1.
- Completion: `i_tx_done` for byte 127 sampled at edge M gives `o_done` = 1 during cycle M+1 and `o_busy` = 0 from cycle M+2.
- Minimum dump length: with `i_tx_done` arriving in the first WAIT cycle, the dump takes 128×2 + 1 cycles from accept to `o_done`.
- The earliest new `i_start` is accepted in the cycle after DONE.

## Test plan
- Reset: hold `i_reset` for 3 cycles while toggling `i_start` and `i_tx_done` -> all outputs 0 and no `o_tx_start` during or after reset.
- Full dump: reg k = k, except reg1 = 0xDEADBEEF; the TX model pulses `i_tx_done` 3 cycles after each `o_tx_start` -> exactly 128 strobes; bytes 0..3 = 00 00 00 00, bytes 4..7 = DE AD BE EF, bytes 124..127 = 00 00 00 1F; single `o_done` one cycle after the 128th `i_tx_done`.
- Snapshot isolation: start with reg5 = 0x12345678, then change reg5 to 0xFFFFFFFF on the next cycle -> bytes 20..23 = 12 34 56 78.
- Protocol robustness: pulse `i_start` mid-dump and pulse `i_tx_done` during SEND cycles -> still exactly 128 strobes, no restart, no skipped byte.
- Reset mid-dump: assert `i_reset` after byte 50 is strobed -> IDLE next cycle, no `o_done`; a new start then emits byte 0 first.
- Back-to-back: `i_start` held high continuously with immediate `i_tx_done` -> second dump accepted in the cycle after DONE; first strobe 2 cycles after the `o_done` cycle.
